// File: rtl/tty_text_render.sv
// Text-mode raster renderer: char RAM -> font ROM -> 8-pixel shifter -> RGB565 stream.
// Latency: first px_valid RAM_LAT+3 cycles after entering FETCH; bubble-free within a frame.
// Backpressure: px_valid/px_ready; outputs held while stalled, fetch waits on a full glyph buffer.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   enable              frames render back to back while high (sampled at frame boundaries)
//   ram_*               read-only master on the character RAM (address = text_row*COLS + col)
//   font_address/data   font ROM, {char_code, glyph_row}, 1-cycle read latency, bit 7 leftmost
//   px_data/valid/ready RGB565 pixel stream with px_sof (first pixel) and px_eol (last of line)
//   busy                frame in progress
// Build option TTY_ATTR_RAM_EN: adds attr_chipselect/attr_readdata; per-cell colours come from
// the attribute byte ({bg_idx, fg_idx}) through the 16-entry VGA palette instead of FG/BG_COLOR.

module tty_text_render #(
  parameter int          COLS     = 40,
  parameter int          ROWS     = 15,
  parameter int          CHAR_H   = 16,
  parameter int          RAM_LAT  = 1,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] ram_address,
  output logic        ram_chipselect,
  output logic        ram_clken,
  output logic        ram_write,
  output logic [7:0]  ram_writedata,
  input  logic [7:0]  ram_readdata,
`ifdef TTY_ATTR_RAM_EN
  output logic        attr_chipselect,
  input  logic [7:0]  attr_readdata,
`endif
  output logic [11:0] font_address,
  input  logic [7:0]  font_data,
  output logic [15:0] px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_sof,
  output logic        px_eol,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_nxt;

  // fetch-side position of the next cell to read
  logic [15:0] f_col, f_trow, row_base;
  logic [3:0]  f_grow;
  logic        col_end, grow_end, trow_end, cell_first, cell_last;

  // one fetch in flight at a time; pipe tracks it through RAM and font latency
  logic [RAM_LAT:0] pipe;
  logic             rd_vld, font_vld, issue;
  logic [3:0]       fl_row;
  logic             fl_sof, fl_eol, fl_last;

  // single-entry glyph buffer between fetcher and shifter
  logic       buf_full, buf_sof, buf_eol, buf_last;
  logic [7:0] buf_glyph;

  // pixel shifter
  logic       sh_vld, sh_sof, sh_eol, sh_last;
  logic [7:0] sh_glyph;
  logic [2:0] sh_cnt;
  logic       accept, sh_done, buf_load, last_accept;
  logic [15:0] fg, bg;

`ifdef TTY_ATTR_RAM_EN
  logic [7:0] fl_attr, buf_attr, sh_attr;

  function automatic logic [15:0] vga565(input logic [3:0] idx);
    case (idx)
      4'd0:  vga565 = 16'h0000;
      4'd1:  vga565 = 16'h0015;
      4'd2:  vga565 = 16'h0540;
      4'd3:  vga565 = 16'h0555;
      4'd4:  vga565 = 16'hA800;
      4'd5:  vga565 = 16'hA815;
      4'd6:  vga565 = 16'hAAA0;
      4'd7:  vga565 = 16'hAD55;
      4'd8:  vga565 = 16'h52AA;
      4'd9:  vga565 = 16'h52BF;
      4'd10: vga565 = 16'h57EA;
      4'd11: vga565 = 16'h57FF;
      4'd12: vga565 = 16'hFAAA;
      4'd13: vga565 = 16'hFABF;
      4'd14: vga565 = 16'hFFEA;
      default: vga565 = 16'hFFFF;
    endcase
  endfunction

  assign fg = vga565(sh_attr[3:0]);
  assign bg = vga565(sh_attr[7:4]);
  assign attr_chipselect = issue;
`else
  assign fg = FG_COLOR;
  assign bg = BG_COLOR;
`endif

  assign col_end    = (f_col == 16'(COLS - 1));
  assign grow_end   = (f_grow == 4'(CHAR_H - 1));
  assign trow_end   = (f_trow == 16'(ROWS - 1));
  assign cell_first = (f_col == 16'd0) && (f_grow == 4'd0) && (f_trow == 16'd0);
  assign cell_last  = col_end && grow_end && trow_end;

  assign rd_vld   = pipe[RAM_LAT-1];
  assign font_vld = pipe[RAM_LAT];

  assign accept      = sh_vld && px_ready;
  assign sh_done     = accept && (sh_cnt == 3'd7);
  assign buf_load    = buf_full && (!sh_vld || sh_done);
  assign last_accept = sh_done && sh_last;

  // Refill the buffer as soon as it is empty or being drained this cycle; fetch latency
  // (RAM_LAT+2) is shorter than the 8 pixels a cell takes, so the shifter never starves.
  assign issue = (state == FETCH) && !(|pipe) && (!buf_full || buf_load);

  assign ram_clken      = 1'b1;
  assign ram_write      = 1'b0;
  assign ram_writedata  = 8'h00;
  assign ram_chipselect = issue;
  assign ram_address    = issue ? (row_base + f_col) : 16'h0000;
  assign font_address   = rd_vld ? {ram_readdata, fl_row} : 12'h000;

  assign px_valid = sh_vld;
  assign px_data  = sh_vld ? (sh_glyph[3'd7 - sh_cnt] ? fg : bg) : 16'h0000;
  assign px_sof   = sh_vld && sh_sof && (sh_cnt == 3'd0);
  assign px_eol   = sh_vld && sh_eol && (sh_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (issue && cell_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // enable only matters here, at the frame boundary
        if (last_accept) state_nxt = enable ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_col     <= '0;
      f_grow    <= '0;
      f_trow    <= '0;
      row_base  <= '0;
      pipe      <= '0;
      fl_row    <= '0;
      fl_sof    <= 1'b0;
      fl_eol    <= 1'b0;
      fl_last   <= 1'b0;
      buf_full  <= 1'b0;
      buf_glyph <= '0;
      buf_sof   <= 1'b0;
      buf_eol   <= 1'b0;
      buf_last  <= 1'b0;
      sh_vld    <= 1'b0;
      sh_glyph  <= '0;
      sh_cnt    <= '0;
      sh_sof    <= 1'b0;
      sh_eol    <= 1'b0;
      sh_last   <= 1'b0;
`ifdef TTY_ATTR_RAM_EN
      fl_attr   <= '0;
      buf_attr  <= '0;
      sh_attr   <= '0;
`endif
    end else begin
      pipe <= {pipe[RAM_LAT-1:0], issue};

      if (issue) begin
        fl_row  <= f_grow;
        fl_sof  <= cell_first;
        fl_eol  <= col_end;
        fl_last <= cell_last;
        if (col_end) begin
          f_col <= '0;
          if (grow_end) begin
            f_grow <= '0;
            if (trow_end) begin
              f_trow   <= '0;
              row_base <= '0;
            end else begin
              f_trow   <= f_trow + 16'd1;
              row_base <= row_base + 16'(COLS);
            end
          end else begin
            // same text row again for the next glyph row (no line buffer)
            f_grow <= f_grow + 4'd1;
          end
        end else begin
          f_col <= f_col + 16'd1;
        end
      end

`ifdef TTY_ATTR_RAM_EN
      if (rd_vld) fl_attr <= attr_readdata;
`endif

      if (font_vld) begin
        buf_full  <= 1'b1;
        buf_glyph <= font_data;
        buf_sof   <= fl_sof;
        buf_eol   <= fl_eol;
        buf_last  <= fl_last;
`ifdef TTY_ATTR_RAM_EN
        buf_attr  <= fl_attr;
`endif
      end else if (buf_load) begin
        buf_full <= 1'b0;
      end

      if (buf_load) begin
        sh_vld   <= 1'b1;
        sh_cnt   <= 3'd0;
        sh_glyph <= buf_glyph;
        sh_sof   <= buf_sof;
        sh_eol   <= buf_eol;
        sh_last  <= buf_last;
`ifdef TTY_ATTR_RAM_EN
        sh_attr  <= buf_attr;
`endif
      end else if (accept) begin
        if (sh_cnt == 3'd7) sh_vld <= 1'b0;
        else                sh_cnt <= sh_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_tty_text_render.sv
// Bench for tty_text_render on a small 4x2-cell, 2-row-glyph screen (128 pixels per frame).
// Table-driven pixel vectors plus reference-model stream checks, backpressure and reset sequences.
// Summary line: CHECKS <n> ERRORS <n>.

module tb_tty_text_render;

  localparam int COLS    = 4;
  localparam int ROWS    = 2;
  localparam int CHAR_H  = 2;
  localparam int RAM_LAT = 1;
  localparam int LINE    = COLS * 8;
  localparam int NPX     = LINE * ROWS * CHAR_H;
  localparam int NCELL   = COLS * ROWS * CHAR_H;

  logic        clk, reset, enable;
  logic [15:0] ram_address;
  logic        ram_chipselect, ram_clken, ram_write;
  logic [7:0]  ram_writedata, ram_readdata;
  logic [11:0] font_address;
  logic [7:0]  font_data;
  logic [15:0] px_data;
  logic        px_valid, px_ready, px_sof, px_eol, busy;
`ifdef TTY_ATTR_RAM_EN
  logic        attr_chipselect;
  logic [7:0]  attr_readdata;
  logic [7:0]  attr_mem [0:255];
`endif

  logic [7:0] ram_mem  [0:255];
  logic [7:0] font_mem [0:4095];

  int checks, errors, cyc, rdy_mode;

  tty_text_render #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .RAM_LAT(RAM_LAT),
    .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
`ifdef TTY_ATTR_RAM_EN
    .attr_chipselect(attr_chipselect), .attr_readdata(attr_readdata),
`endif
    .font_address(font_address), .font_data(font_data),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_sof(px_sof), .px_eol(px_eol), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory models: char/attr RAM with 1-cycle latency, font ROM with 1-cycle latency
  always @(posedge clk) begin
    ram_readdata <= ram_mem[ram_address[7:0]];
    font_data    <= font_mem[font_address];
`ifdef TTY_ATTR_RAM_EN
    attr_readdata <= attr_mem[ram_address[7:0]];
`endif
  end

  // sink ready pattern: 0 = always ready, 1 = toggle every cycle
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) px_ready = ~px_ready;
      else               px_ready = 1'b1;
    end
  end

  // monitor: captures accepted pixels and issued addresses, checks stall stability
  logic [15:0] cap_data[$];
  logic        cap_sof[$], cap_eol[$];
  int          cap_cyc[$], adr_q[$], adr_cyc[$];
  int          stall_err, stall_cnt;
  logic        prev_stall, prev_sof, prev_eol;
  logic [15:0] prev_data;

  initial begin
    cyc = 0; stall_err = 0; stall_cnt = 0; prev_stall = 1'b0;
    prev_data = '0; prev_sof = 1'b0; prev_eol = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (prev_stall && (px_valid !== 1'b1 || px_data !== prev_data ||
                           px_sof !== prev_sof || px_eol !== prev_eol))
          stall_err++;
        if (px_valid && px_ready) begin
          cap_data.push_back(px_data);
          cap_sof.push_back(px_sof);
          cap_eol.push_back(px_eol);
          cap_cyc.push_back(cyc);
        end
        if (ram_chipselect) begin
          adr_q.push_back(int'(ram_address));
          adr_cyc.push_back(cyc);
        end
        if (px_valid && !px_ready) stall_cnt++;
        prev_stall = px_valid && !px_ready;
      end else begin
        prev_stall = 1'b0;
      end
      prev_data = px_data; prev_sof = px_sof; prev_eol = px_eol;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_px(input int target, input int budget);
    int n;
    n = 0;
    while (cap_data.size() < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_px_timeout", (cap_data.size() >= target) ? 1 : 0, 1);
  endtask

  // reference model of pixel n of a frame: {sof, eol, data} (white-on-black)
  function automatic logic [17:0] model_px(input int n);
    int line, x, col, trow, grow;
    logic [7:0] code, g;
    logic [11:0] fa;
    line = n / LINE;
    x    = n % LINE;
    col  = x / 8;
    trow = line / CHAR_H;
    grow = line % CHAR_H;
    code = ram_mem[trow * COLS + col];
    fa   = {code, 4'(grow)};
    g    = font_mem[fa];
    model_px = {(n == 0), (x == LINE - 1), (g[7 - (x % 8)] ? 16'hFFFF : 16'h0000)};
  endfunction

  task automatic check_frame(input string name, input int base);
    int bad;
    logic [17:0] e;
    bad = 0;
    for (int i = 0; i < NPX; i++) begin
      e = model_px(i);
      if (base + i >= cap_data.size()) bad++;
      else if (cap_data[base+i] !== e[15:0] || cap_eol[base+i] !== e[16] ||
               cap_sof[base+i] !== e[17]) bad++;
    end
    check({name, "_stream_mismatches"}, bad, 0);
  endtask

  task automatic check_addr(input string name, input int abase);
    int bad, k;
    bad = 0; k = 0;
    for (int tr = 0; tr < ROWS; tr++)
      for (int gr = 0; gr < CHAR_H; gr++)
        for (int c = 0; c < COLS; c++) begin
          if (abase + k >= adr_q.size() || adr_q[abase+k] != tr * COLS + c) bad++;
          k++;
        end
    check({name, "_addr_mismatches"}, bad, 0);
  endtask

  task automatic count_flags(input int base, input int n, output int nsof, output int neol);
    nsof = 0; neol = 0;
    for (int i = base; i < base + n && i < cap_data.size(); i++) begin
      if (cap_sof[i]) nsof++;
      if (cap_eol[i]) neol++;
    end
  endtask

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int pb, ab, nsof, neol, gaps, se, sc;

  initial begin
    checks = 0; errors = 0; rdy_mode = 0;
    reset = 1'b1; enable = 1'b0;

    for (int a = 0; a < 4096; a++) font_mem[a] = 8'(a * 37 + 11);
    for (int a = 0; a < 256; a++) ram_mem[a] = 8'h20;
    for (int a = 0; a < COLS * ROWS; a++) ram_mem[a] = 8'(8'h41 + a);
`ifdef TTY_ATTR_RAM_EN
    for (int a = 0; a < 256; a++) attr_mem[a] = 8'h0F;
`endif
    font_mem[12'h410] = 8'h81;  // 'A' row 0, cell (0,0)
    font_mem[12'h420] = 8'h0F;  // cell col 1, row 0
    font_mem[12'h440] = 8'h01;  // cell col 3, row 0 (end of line 0)
    font_mem[12'h411] = 8'h00;  // cell col 0, glyph row 1
    font_mem[12'h441] = 8'h01;  // end of line 1
    font_mem[12'h450] = 8'h80;  // text row 1, col 0
    font_mem[12'h481] = 8'hFE;  // very last cell of the frame

    vecs[0]  = '{0,   16'hFFFF, 1'b1, 1'b0};
    vecs[1]  = '{1,   16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{3,   16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{6,   16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{7,   16'hFFFF, 1'b0, 1'b0};
    vecs[5]  = '{8,   16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{12,  16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{31,  16'hFFFF, 1'b0, 1'b1};
    vecs[8]  = '{32,  16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{63,  16'hFFFF, 1'b0, 1'b1};
    vecs[10] = '{127, 16'h0000, 1'b0, 1'b1};

    // reset held 3 cycles
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_px_valid", px_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_chipselect", ram_chipselect, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_clken", ram_clken, 1);
    check("rst_px_data", px_data, 0);
    check("rst_font_address", font_address, 0);

    // gapless frame, enable dropped mid-frame
    pb = cap_data.size(); ab = adr_q.size();
    enable = 1'b1;
    wait_px(pb + 10, 200);
    check("busy_mid_frame", busy, 1);
    enable = 1'b0;
    wait_px(pb + NPX, 400);
    repeat (20) tick();
    check("busy_after_frame", busy, 0);
    check("no_extra_px", cap_data.size() - pb, NPX);
    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d_px%0d_data", i, vecs[i].idx), cap_data[pb+vecs[i].idx], vecs[i].data);
      check($sformatf("vec%0d_px%0d_sof", i, vecs[i].idx), cap_sof[pb+vecs[i].idx], vecs[i].sof);
      check($sformatf("vec%0d_px%0d_eol", i, vecs[i].idx), cap_eol[pb+vecs[i].idx], vecs[i].eol);
    end
    check_frame("gapless", pb);
    check_addr("gapless", ab);
    check("gapless_addr_count", adr_q.size() - ab, NCELL);
    check("first_px_latency", cap_cyc[pb] - adr_cyc[ab], RAM_LAT + 3);
    gaps = 0;
    for (int i = pb; i < pb + NPX - 1; i++) if (cap_cyc[i+1] - cap_cyc[i] != 1) gaps++;
    check("gapless_bubbles", gaps, 0);
    count_flags(pb, NPX, nsof, neol);
    check("gapless_sof_count", nsof, 1);
    check("gapless_eol_count", neol, ROWS * CHAR_H);

    // backpressure: ready toggles every cycle
    rdy_mode = 1;
    se = stall_err; sc = stall_cnt;
    pb = cap_data.size(); ab = adr_q.size();
    enable = 1'b1;
    wait_px(pb + 10, 400);
    enable = 1'b0;
    wait_px(pb + NPX, 1200);
    repeat (20) tick();
    rdy_mode = 0;
    check_frame("backpressure", pb);
    check_addr("backpressure", ab);
    check("bp_stall_unstable", stall_err - se, 0);
    check("bp_stalls_seen", (stall_cnt - sc > 0) ? 1 : 0, 1);
    check("bp_no_extra_px", cap_data.size() - pb, NPX);
    check("bp_busy_after", busy, 0);

    // two frames back to back, enable dropped inside the second
    pb = cap_data.size(); ab = adr_q.size();
    enable = 1'b1;
    wait_px(pb + NPX + 10, 800);
    enable = 1'b0;
    wait_px(pb + 2 * NPX, 800);
    repeat (20) tick();
    check_frame("frame2a", pb);
    check_frame("frame2b", pb + NPX);
    count_flags(pb, 2 * NPX, nsof, neol);
    check("two_frames_sof_count", nsof, 2);
    check("two_frames_px_count", cap_data.size() - pb, 2 * NPX);
    check("two_frames_addr_count", adr_q.size() - ab, 2 * NCELL);

    // reset pulse mid-frame
    pb = cap_data.size();
    enable = 1'b1;
    wait_px(pb + 50, 400);
    reset = 1'b1;
    tick();
    check("reset_mid_px_valid", px_valid, 0);
    check("reset_mid_busy", busy, 0);
    reset = 1'b0;
    pb = cap_data.size(); ab = adr_q.size();
    wait_px(pb + 10, 400);
    enable = 1'b0;
    wait_px(pb + NPX, 400);
    repeat (20) tick();
    check("restart_addr0", (adr_q.size() > ab) ? adr_q[ab] : -1, 0);
    check("restart_sof", cap_sof[pb], 1);
    check_frame("restart", pb);
    check("restart_px_count", cap_data.size() - pb, NPX);

`ifdef TTY_ATTR_RAM_EN
    // attribute colours: fg 15 (white), bg 4 (red)
    attr_mem[0] = 8'h4F;
    font_mem[12'h410] = 8'h80;
    pb = cap_data.size();
    enable = 1'b1;
    wait_px(pb + 8, 400);
    enable = 1'b0;
    wait_px(pb + NPX, 400);
    repeat (20) tick();
    check("attr_px0", cap_data[pb], 16'hFFFF);
    for (int i = 1; i < 8; i++) check($sformatf("attr_px%0d", i), cap_data[pb+i], 16'hA800);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
